// File: rtl/ft2232h_tx_fifo.sv
// +----------------------------------------------------------------------------+
// | Module   : ft2232h_tx_fifo                                                 |
// | Function : word FIFO plus LSB-first byte serializer driving FT2232H        |
// |            synchronous-FIFO TX (WR#/TXE#), clocked by the chip CLKOUT.     |
// |            Define FT_TX_STATS_EN to add tx_count_o / stall_count_o.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module ft2232h_tx_fifo #(
  parameter int WORD_BYTES = 2,
  parameter int DEPTH      = 16
) (
  input  logic                      clkout_i,
  input  logic                      rst_n_i,
  input  logic [8*WORD_BYTES-1:0]   wdata_i,
  input  logic                      wvalid_i,
  output logic                      wready_o,
  output logic [$clog2(DEPTH):0]    level_o,
  input  logic                      txe_i,
  output logic                      wr_o,
  output logic [7:0]                data_o
`ifdef FT_TX_STATS_EN
  ,
  output logic [31:0]               tx_count_o,
  output logic [15:0]               stall_count_o
`endif
);

  localparam int c_addr_w = $clog2(DEPTH);
  localparam int c_word_w = 8 * WORD_BYTES;
  localparam int c_idx_w  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [c_addr_w:0]  c_full    = (c_addr_w + 1)'(DEPTH);
  localparam logic [c_addr_w:0]  c_lvl_one = (c_addr_w + 1)'(1);
  localparam logic [c_addr_w-1:0] c_ptr_one = c_addr_w'(1);
  localparam logic [c_idx_w-1:0] c_last    = c_idx_w'(WORD_BYTES - 1);
  localparam logic [c_idx_w-1:0] c_idx_one = c_idx_w'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  generate
    if (WORD_BYTES < 1 || WORD_BYTES > 4) begin : g_bad_word_bytes
      $error("WORD_BYTES must be in 1..4");
    end
    if (DEPTH < 4 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("DEPTH must be a power of two in 4..64");
    end
  endgenerate

  logic [c_word_w-1:0] r_mem [DEPTH];
  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [c_addr_w:0]   r_level;
  logic [c_word_w-1:0] r_word;
  logic [c_idx_w-1:0]  r_idx;
  state_t              r_state;

  state_t              w_state_nxt;
  logic [c_idx_w-1:0]  w_idx_nxt;
  logic                w_push;
  logic                w_pop;
  logic                w_empty;
  logic                w_xfer;
  logic [7:0]          w_bytes [WORD_BYTES];

  // All outputs decode registers only; txe_i/wvalid_i never reach a port.
  assign wready_o = (r_level != c_full);
  assign level_o  = r_level;
  assign wr_o     = (r_state != ST_SEND);
  assign w_empty  = (r_level == '0);
  assign w_push   = wvalid_i & wready_o;
  assign w_xfer   = (r_state == ST_SEND) & ~txe_i;

  generate
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_bytes
      assign w_bytes[gi] = r_word[8*gi +: 8];
    end
  endgenerate

  assign data_o = w_bytes[r_idx];

  always_ff @(posedge clkout_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wdata_i;
    end
  end

  always_ff @(posedge clkout_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_lvl_one;
        2'b01:   r_level <= r_level - c_lvl_one;
        default: r_level <= r_level;
      endcase
    end
  end

  // Serializer: the last byte of a word pops its successor on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pop       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_xfer) begin
          if (r_idx != c_last) begin
            w_idx_nxt = r_idx + c_idx_one;
          end else if (!w_empty) begin
            w_pop     = 1'b1;
            w_idx_nxt = '0;
          end else begin
            w_idx_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_idx_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clkout_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_word  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_pop) r_word <= r_mem[r_rd_ptr];
    end
  end

`ifdef FT_TX_STATS_EN
  logic [31:0] r_tx_count;
  logic [15:0] r_stall_count;

  always_ff @(posedge clkout_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_tx_count    <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_xfer) r_tx_count <= r_tx_count + 32'd1;
      if ((r_state == ST_SEND) && txe_i && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end

  assign tx_count_o    = r_tx_count;
  assign stall_count_o = r_stall_count;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

`default_nettype wire
